sparse_to_dense: RTL
====================

Name: sparse_to_dense

Overview:
- Upstream feeder of the dense XOR adder. Converts a sparse error vector into the dense WIDTH-bit word memory that the adder reads on its second operand port.
- The sparse vector is WEIGHT bit positions, each < N, held in a location memory.
- Clears the dense memory, then sets one bit per location by read-modify-write, sustaining one location per cycle.
- Used in HQC encapsulation to expand the e/r sparse vectors before addition.

Parameters:
- parameter_set, "hqc256", selects N/WEIGHT ("hqc128"/"hqc192"/"hqc256")
- N, 17_669/35_851/57_637 per set, vector length in bits
- WEIGHT, 66/100/131 per set, number of locations
- WIDTH, 128, dense word width; must be a power of two
- N_MEM, N + (WIDTH - N%WIDTH)%WIDTH, padded length
- DEPTH, N_MEM/WIDTH, dense words
- LOG_DEPTH, CLOG2(DEPTH), dense address width
- LOG_N, CLOG2(N), location width
- LOG_WEIGHT, CLOG2(WEIGHT), location address width
- LOG_WIDTH, CLOG2(WIDTH), bit-index width

Ports:
- clk  input  1  clock
- rst  input  1  reset; asynchronous, active-low
- start  input  1  single-cycle request; sampled only in S_IDLE
- loc_addr  output  LOG_WEIGHT  location memory read address
- loc_rd_en  output  1  location read enable; data valid 1 cycle later
- loc_in  input  LOG_N  location read data
- din_addr  output  LOG_DEPTH  dense memory read address
- din_rd_en  output  1  dense read enable; 1-cycle latency; read-first memory
- din  input  WIDTH  dense read data
- dout_addr  output  LOG_DEPTH  dense write address
- dout  output  WIDTH  dense write data
- dout_wr_en  output  1  dense write enable
- busy  output  1  high from the cycle after start until done
- err  output  1  sticky out-of-range flag; cleared on the next start
- done  output  1  one-cycle completion pulse

Behaviour:
- Reset (rst=0, asynchronous): state S_IDLE; all outputs, addresses and pipeline valids are 0. Dense memory contents are undefined afterwards.
- Timing is counted from start sampled in S_IDLE at cycle 0.
- S_CLEAR (cycles 1..DEPTH):
  - dout_wr_en=1, dout=0, dout_addr=0..DEPTH-1.
  - loc_rd_en=1, loc_addr=0 in the last CLEAR cycle (prefetch).
- S_LOAD (cycles DEPTH+1..DEPTH+WEIGHT): location i issued in cycle DEPTH+1+i. Pipeline:
  - Stage 1 (cycle after issue): w = loc_in >> LOG_WIDTH, b = loc_in[LOG_WIDTH-1:0]. din_rd_en=1, din_addr=w.
  - Stage 2: base = forward ? stage-2 data of the previous location : din. dout = base | (1<<b), dout_addr=w, dout_wr_en=1.
- Forwarding: forward = previous location valid in stage 2 and same w.
  - Covers the same-cycle read/write collision, because the memory is read-first.
  - A gap of two or more cycles needs no forwarding.
- Out-of-range: loc_in >= N drops the location from stage 1 (no read, no write) and sets err=1. The pipeline keeps flowing.
- Duplicate locations are idempotent (OR).
- S_DRAIN (2 cycles): flushes stages 1 and 2. The last write occurs at cycle DEPTH+WEIGHT+2.
- S_DONE: done=1 at cycle DEPTH+WEIGHT+3, busy=0 in the same cycle, then return to S_IDLE.
- start is ignored while busy. start may be re-asserted the cycle after done.
- Throughput: one location per cycle with no stalls.
- Every write completes before done, so the adder may start on done.

Decomposition:
- Shared package/header holds the per-set constants (N, WEIGHT, M), N_MEM/DEPTH derivation, CLOG2, and the state encodings S_IDLE/S_CLEAR/S_LOAD/S_DRAIN/S_DONE.
- One natural sub-module: loc_to_word_bit, the registered stage 1. It splits a location into word address and bit index and produces the range check (err_hit).

Test Plan:
- hqc128 (DEPTH=139, WEIGHT=66); locations {0,1,127,128,17668} plus 61 copies of 0 -> word0=bits{0,1,127}, word1=0x1, word138=0x10, all other words 0; err=0.
- Consecutive same-word locations {5,5,6,300,6} -> word0=0x60, word2=bit 44; confirms forwarding loses no bit.
- Location 17669 (=N) in slot 10 -> err=1, no write issued for slot 10, the other 65 bits are set; err clears on the next start.
- Timing: start at cycle 0 -> dout_wr_en high cycles 1..139 with data 0; first location write at cycle 142; done single pulse at cycle 208; busy high cycles 1..207.
- rst driven low mid-S_LOAD -> all outputs 0 in the same cycle (asynchronous); after release, a new start completes with correct contents.
- Back-to-back runs with different location sets -> second image has no stale bits from the first; start pulses during busy are ignored (exactly one done per accepted start).

Source files
------------

// File: rtl/sparse_to_dense_pkg.sv
// Shared constants, helpers and state encoding for the sparse-to-dense
// expander that feeds the dense XOR adder in HQC encapsulation.
package sparse_to_dense_pkg;

   // Vector length in bits for each HQC security level
   localparam int N_HQC128 = 17_669;
   localparam int N_HQC192 = 35_851;
   localparam int N_HQC256 = 57_637;

   // Number of set positions in the sparse vector for each level
   localparam int WEIGHT_HQC128 = 66;
   localparam int WEIGHT_HQC192 = 100;
   localparam int WEIGHT_HQC256 = 131;

   // Ceiling log2; clog2(1) is 0
   function automatic int clog2(input int value);
      int result;
      int remain;
      result = 0;
      remain = value - 1;
      while (remain > 0) begin
         result = result + 1;
         remain = remain >> 1;
      end
      return result;
   endfunction

   // Vector length rounded up to a whole number of dense words
   function automatic int calc_n_mem(input int n, input int width);
      return n + (width - n % width) % width;
   endfunction

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLEAR,
      S_LOAD,
      S_DRAIN,
      S_DONE
   } state_t;

endpackage

// File: rtl/sparse_to_dense_loc_to_word_bit.sv
// Registered stage 1: splits a location into dense word address and bit
// index, and flags locations that fall outside the vector.
module loc_to_word_bit
   import sparse_to_dense_pkg::*;
#(
   parameter int N         = N_HQC256,
   parameter int LOG_N     = clog2(N),
   parameter int LOG_DEPTH = 9,
   parameter int LOG_WIDTH = 7
)(
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic                 i_valid,
   input  logic [LOG_N-1:0]     i_loc,
   output logic                 o_valid,
   output logic [LOG_DEPTH-1:0] o_word,
   output logic [LOG_WIDTH-1:0] o_bit,
   output logic                 o_err_hit
);

   logic w_in_range;

   // Out-of-range locations are compared at 32 bits so N == 2**LOG_N also works
   always_comb begin
      w_in_range = (32'(i_loc) < 32'(N));
   end

   // Capture the split location; a bad location is dropped but reported
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_valid   <= 1'b0;
         o_word    <= '0;
         o_bit     <= '0;
         o_err_hit <= 1'b0;
      end else begin
         o_valid   <= i_valid & w_in_range;
         o_err_hit <= i_valid & ~w_in_range;
         o_word    <= LOG_DEPTH'(i_loc >> LOG_WIDTH);
         o_bit     <= i_loc[LOG_WIDTH-1:0];
      end
   end

endmodule

// File: rtl/sparse_to_dense.sv
// Expands a sparse list of bit positions into a dense word memory: clears
// every word, then ORs one bit per location with a read-modify-write
// pipeline that accepts one location per cycle.
module sparse_to_dense
   import sparse_to_dense_pkg::*;
#(
   parameter string PARAMETER_SET = "hqc256",
   parameter int N          = (PARAMETER_SET == "hqc128") ? N_HQC128 :
                              (PARAMETER_SET == "hqc192") ? N_HQC192 : N_HQC256,
   parameter int WEIGHT     = (PARAMETER_SET == "hqc128") ? WEIGHT_HQC128 :
                              (PARAMETER_SET == "hqc192") ? WEIGHT_HQC192 : WEIGHT_HQC256,
   parameter int WIDTH      = 128,
   parameter int N_MEM      = calc_n_mem(N, WIDTH),
   parameter int DEPTH      = N_MEM / WIDTH,
   parameter int LOG_DEPTH  = clog2(DEPTH),
   parameter int LOG_N      = clog2(N),
   parameter int LOG_WEIGHT = clog2(WEIGHT),
   parameter int LOG_WIDTH  = clog2(WIDTH)
)(
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_start,
   output logic [LOG_WEIGHT-1:0] o_loc_addr,
   output logic                  o_loc_rd_en,
   input  logic [LOG_N-1:0]      i_loc_in,
   output logic [LOG_DEPTH-1:0]  o_din_addr,
   output logic                  o_din_rd_en,
   input  logic [WIDTH-1:0]      i_din,
   output logic [LOG_DEPTH-1:0]  o_dout_addr,
   output logic [WIDTH-1:0]      o_dout,
   output logic                  o_dout_wr_en,
   output logic                  o_busy,
   output logic                  o_err,
   output logic                  o_done
);

   localparam int CNT_W = ((LOG_DEPTH > LOG_WEIGHT) ? LOG_DEPTH : LOG_WEIGHT) + 1;

   state_t                r_state;
   state_t                w_next_state;
   logic [CNT_W-1:0]      r_cnt;
   logic                  w_clear_last;
   logic                  w_load_last;
   logic                  w_drain_last;

   logic                  w_s1_in_valid;
   logic                  w_s1_valid;
   logic [LOG_DEPTH-1:0]  w_s1_word;
   logic [LOG_WIDTH-1:0]  w_s1_bit;
   logic                  w_s1_err_hit;

   logic                  r_s2_valid;
   logic [LOG_DEPTH-1:0]  r_s2_word;
   logic [LOG_WIDTH-1:0]  r_s2_bit;

   logic                  r_wr_valid;
   logic [LOG_DEPTH-1:0]  r_wr_word;
   logic [WIDTH-1:0]      r_wr_data;

   logic                  w_forward;
   logic [WIDTH-1:0]      w_s2_base;
   logic [WIDTH-1:0]      w_s2_data;
   logic                  r_err;

   // Phase end markers derived from the per-phase counter
   always_comb begin
      w_clear_last = (r_cnt == CNT_W'(DEPTH - 1));
      w_load_last  = (r_cnt == CNT_W'(WEIGHT - 1));
      w_drain_last = (r_cnt == CNT_W'(1));
   end

   // State register
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state logic: clear, stream locations, flush the two stages, report
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE:  if (i_start)      w_next_state = S_CLEAR;
         S_CLEAR: if (w_clear_last) w_next_state = S_LOAD;
         S_LOAD:  if (w_load_last)  w_next_state = S_DRAIN;
         S_DRAIN: if (w_drain_last) w_next_state = S_DONE;
         S_DONE:                    w_next_state = S_IDLE;
         default:                   w_next_state = S_IDLE;
      endcase
   end

   // Per-phase counter, restarted at every state change
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cnt <= '0;
      end else if (r_state != w_next_state) begin
         r_cnt <= '0;
      end else if (r_state == S_CLEAR || r_state == S_LOAD || r_state == S_DRAIN) begin
         r_cnt <= r_cnt + CNT_W'(1);
      end
   end

   // Location data returned by the memory is valid on every LOAD cycle
   always_comb begin
      w_s1_in_valid = (r_state == S_LOAD);
   end

   loc_to_word_bit #(
      .N         (N),
      .LOG_N     (LOG_N),
      .LOG_DEPTH (LOG_DEPTH),
      .LOG_WIDTH (LOG_WIDTH)
   ) u_stage1 (
      .i_clk     (i_clk),
      .i_rst_n   (i_rst_n),
      .i_valid   (w_s1_in_valid),
      .i_loc     (i_loc_in),
      .o_valid   (w_s1_valid),
      .o_word    (w_s1_word),
      .o_bit     (w_s1_bit),
      .o_err_hit (w_s1_err_hit)
   );

   // Stage 2 holds the location whose dense word arrives on i_din this cycle
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_s2_valid <= 1'b0;
         r_s2_word  <= '0;
         r_s2_bit   <= '0;
      end else begin
         r_s2_valid <= w_s1_valid;
         r_s2_word  <= w_s1_word;
         r_s2_bit   <= w_s1_bit;
      end
   end

   // Remember the previous stage-2 write; its read was issued the same cycle
   // as that write, so a read-first memory hands back the stale word
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wr_valid <= 1'b0;
         r_wr_word  <= '0;
         r_wr_data  <= '0;
      end else begin
         r_wr_valid <= r_s2_valid;
         r_wr_word  <= r_s2_word;
         r_wr_data  <= w_s2_data;
      end
   end

   // Merge: take the forwarded word on a back-to-back hit, then OR in the bit
   always_comb begin
      w_forward = r_wr_valid && (r_wr_word == r_s2_word);
      w_s2_base = w_forward ? r_wr_data : i_din;
      w_s2_data = w_s2_base | (WIDTH'(1) << r_s2_bit);
   end

   // Sticky out-of-range flag, cleared when a new run is accepted
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_err <= 1'b0;
      end else if (r_state == S_IDLE && i_start) begin
         r_err <= 1'b0;
      end else if (w_s1_err_hit) begin
         r_err <= 1'b1;
      end
   end

   // Output decode from state, counter and pipeline valids
   always_comb begin
      o_loc_addr   = '0;
      o_loc_rd_en  = 1'b0;
      o_din_addr   = '0;
      o_din_rd_en  = 1'b0;
      o_dout_addr  = '0;
      o_dout       = '0;
      o_dout_wr_en = 1'b0;
      o_busy       = (r_state == S_CLEAR) || (r_state == S_LOAD) || (r_state == S_DRAIN);
      o_done       = (r_state == S_DONE);
      o_err        = r_err;
      if (r_state == S_CLEAR) begin
         o_dout_wr_en = 1'b1;
         o_dout_addr  = LOG_DEPTH'(r_cnt);
         if (w_clear_last) begin
            o_loc_rd_en = 1'b1;
         end
      end
      if (r_state == S_LOAD && !w_load_last) begin
         o_loc_rd_en = 1'b1;
         o_loc_addr  = LOG_WEIGHT'(r_cnt + CNT_W'(1));
      end
      if (w_s1_valid) begin
         o_din_rd_en = 1'b1;
         o_din_addr  = w_s1_word;
      end
      if (r_s2_valid) begin
         o_dout_wr_en = 1'b1;
         o_dout_addr  = r_s2_word;
         o_dout       = w_s2_data;
      end
   end

endmodule
